// File: rtl/data_memory_ws_if.sv
// Datapath <-> data memory bus bundle for data_memory_ws.
// master: datapath side (address/data/request, consumes results)
// slave : memory side (drives write-back value, stall, error flag)
// Signals:
//   alu_result_address - access address and bypass value
//   write_data         - store data
//   memread/memwrite   - level requests, held until the instruction completes
//   memory_to_register - write-back select (1 = read data, 0 = ALU result)
//   output_mux3        - write-back value
//   stall              - datapath hold
//   mem_error          - one-cycle illegal-access flag
interface data_memory_ws_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] alu_result_address;
    logic [DATA_W-1:0] write_data;
    logic              memread;
    logic              memwrite;
    logic              memory_to_register;
    logic [DATA_W-1:0] output_mux3;
    logic              stall;
    logic              mem_error;

    modport master (
        output alu_result_address,
        output write_data,
        output memread,
        output memwrite,
        output memory_to_register,
        input  output_mux3,
        input  stall,
        input  mem_error
    );

    modport slave (
        input  alu_result_address,
        input  write_data,
        input  memread,
        input  memwrite,
        input  memory_to_register,
        output output_mux3,
        output stall,
        output mem_error
    );
endinterface

// File: rtl/data_memory_ws.sv
// Wait-state data memory: latches a request, stalls the datapath for
// WAIT_STATES+2 cycles, registers read data and selects the write-back value.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset (array contents untouched)
//   bus   - data_memory_ws_if slave (request in; output_mux3/stall/mem_error out)
module data_memory_ws #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic            clk,
    input  logic            reset,
    data_memory_ws_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              oob_q, oob_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              req;
    logic              req_oob;
    logic              access;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] words [DEPTH];

    assign req     = bus.memread | bus.memwrite;
    assign req_oob = {1'b0, bus.alu_result_address}
                     >= (ADDR_W+1)'(DEPTH);

    // The access edge is the last BUSY cycle; a reset on that edge wins
    // so that an interrupted store never lands.
    assign access = (state_q == BUSY) && (cnt_q == 4'd0);
    assign wr_en  = access && wr_q && !oob_q && !reset;

    // Each word powers up holding its own index; reset leaves it alone.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_W-1:0] word_q = DATA_W'(i);

        always_ff @(posedge clk) begin
            if (wr_en && (addr_q == ADDR_W'(i))) begin
                word_q <= wdata_q;
            end
        end

        assign words[i] = word_q;
    end

    // Only legal indices are decoded; out-of-range reads never use this.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == ADDR_W'(i)) begin
                rd_word = words[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        oob_d   = oob_q;
        err_d   = err_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = bus.alu_result_address;
                    wdata_d = bus.write_data;
                    rd_d    = bus.memread;
                    wr_d    = bus.memwrite;
                    oob_d   = req_oob;
                    err_d   = req_oob
                              | (bus.memread & bus.memwrite);
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (oob_q) begin
                        rdata_d = '0;
                    end else if (rd_q && wr_q) begin
                        // Combined op behaves as write-through.
                        rdata_d = wdata_q;
                    end else if (rd_q) begin
                        rdata_d = rd_word;
                    end
                end
            end
            DONE: begin
                // The request still belongs to the completing instruction.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            oob_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            oob_q   <= oob_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Stall is combinational so the very first request cycle holds the
    // datapath.
    assign bus.stall = ((state_q == IDLE) && req) || (state_q == BUSY);

    assign bus.mem_error = (state_q == DONE) && err_q;

    assign bus.output_mux3 = bus.memory_to_register
                             ? rdata_q
                             : DATA_W'(bus.alu_result_address);
endmodule

// File: tb/tb_data_memory_ws.sv
// Bench for data_memory_ws: two instances (WS=0/DEPTH=256, WS=4/DEPTH=128)
// checked every cycle against a transaction-level model plus literal values.
module tb_data_memory_ws;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int WS0  = 0;
    localparam int DEP0 = 256;
    localparam int WS1  = 4;
    localparam int DEP1 = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst    [2];
    logic [AW-1:0] addr   [2];
    logic [DW-1:0] wdat   [2];
    logic          rd     [2];
    logic          wr     [2];
    logic          m2r    [2];
    logic [DW-1:0] mux_o  [2];
    logic          stall_o[2];
    logic          err_o  [2];

    data_memory_ws_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    data_memory_ws_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus0.alu_result_address = addr[0];
    assign bus0.write_data         = wdat[0];
    assign bus0.memread            = rd[0];
    assign bus0.memwrite           = wr[0];
    assign bus0.memory_to_register = m2r[0];
    assign mux_o[0]                = bus0.output_mux3;
    assign stall_o[0]              = bus0.stall;
    assign err_o[0]                = bus0.mem_error;

    assign bus1.alu_result_address = addr[1];
    assign bus1.write_data         = wdat[1];
    assign bus1.memread            = rd[1];
    assign bus1.memwrite           = wr[1];
    assign bus1.memory_to_register = m2r[1];
    assign mux_o[1]                = bus1.output_mux3;
    assign stall_o[1]              = bus1.stall;
    assign err_o[1]                = bus1.mem_error;

    data_memory_ws #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP0), .WAIT_STATES(WS0)
    ) u_dut0 (
        .clk  (clk),
        .reset(rst[0]),
        .bus  (bus0)
    );

    data_memory_ws #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP1), .WAIT_STATES(WS1)
    ) u_dut1 (
        .clk  (clk),
        .reset(rst[1]),
        .bus  (bus1)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int k,
                         input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d got=%0h want=%0h t=%0t",
                     nm, k, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted request at cycle t0 occupies
    // cycles t0..t0+ws+1, lands at the end of t0+ws+1, reports in t0+ws+2.
    int ws  [2] = '{WS0, WS1};
    int dep [2] = '{DEP0, DEP1};
    int mm  [2][256];
    bit have[2];
    int t0  [2];
    int la  [2];
    int lwd [2];
    bit lr  [2];
    bit lw  [2];
    bit lerr[2];
    int rdv [2];
    int cyc = 0;

    task automatic model_step(input int k);
        if (rst[k]) begin
            have[k] = 1'b0;
            rdv[k]  = 0;
        end else if (have[k]) begin
            if (cyc == t0[k] + ws[k] + 1) begin
                if (la[k] >= dep[k]) begin
                    rdv[k] = 0;
                end else begin
                    if (lw[k]) mm[k][la[k]] = lwd[k];
                    if (lr[k] && lw[k]) rdv[k] = lwd[k];
                    else if (lr[k]) rdv[k] = mm[k][la[k]];
                end
            end else if (cyc == t0[k] + ws[k] + 2) begin
                have[k] = 1'b0;
            end
        end else if (rd[k] || wr[k]) begin
            have[k] = 1'b1;
            t0[k]   = cyc;
            la[k]   = int'(addr[k]);
            lwd[k]  = int'(wdat[k]);
            lr[k]   = rd[k];
            lw[k]   = wr[k];
            lerr[k] = (rd[k] && wr[k]) || (int'(addr[k]) >= dep[k]);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            have[k] = 1'b0;
            rdv[k]  = 0;
            for (int i = 0; i < 256; i++) mm[k][i] = i % 256;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_step(k);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    logic          e_st;
                    logic          e_er;
                    logic [DW-1:0] e_mx;
                    e_st = (!have[k] && (rd[k] || wr[k]))
                           || (have[k] && cyc <= t0[k] + ws[k] + 1);
                    e_er = have[k] && (cyc == t0[k] + ws[k] + 2) && lerr[k];
                    e_mx = m2r[k] ? DW'(rdv[k]) : DW'(addr[k]);
                    check("stall", k, 32'(stall_o[k]), 32'(e_st));
                    check("mem_error", k, 32'(err_o[k]), 32'(e_er));
                    check("output_mux3", k, 32'(mux_o[k]), 32'(e_mx));
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one memory instruction, hold it until DONE, check the
    // stall length and DONE-cycle outputs against hand values.
    task automatic access(input int k, input logic r, input logic w,
                          input logic m, input logic [7:0] a,
                          input logic [7:0] d, input int exp_st,
                          input logic [7:0] exp_mx, input logic exp_er,
                          input bit scramble);
        int n;
        rd[k]   = r;
        wr[k]   = w;
        m2r[k]  = m;
        addr[k] = a;
        wdat[k] = d;
        n = 0;
        @(negedge clk);
        while (stall_o[k] === 1'b1 && n < 40) begin
            n++;
            if (scramble && n == 2) begin
                addr[k] = ~a;
                wdat[k] = ~d;
            end
            @(negedge clk);
        end
        check("stall_len", k, 32'(n), 32'(exp_st));
        check("done_mux", k, 32'(mux_o[k]), 32'(exp_mx));
        check("done_err", k, 32'(err_o[k]), 32'(exp_er));
        cycle();
        rd[k] = 1'b0;
        wr[k] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]  = 1'b1;
            addr[k] = '0;
            wdat[k] = '0;
            rd[k]   = 1'b0;
            wr[k]   = 1'b0;
            m2r[k]  = 1'b1;
        end
        cycle();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_mux", 0, 32'(mux_o[0]), 32'h0);
        check("rst_stall", 1, 32'(stall_o[1]), 32'h0);
        cycle();
        m2r[0]  = 1'b0;
        addr[0] = 8'h33;
        @(negedge clk);
        check("rst_bypass", 0, 32'(mux_o[0]), 32'h33);
        cycle();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        cycle();

        access(0, 1, 0, 1, 8'h2A, 8'h00, 2, 8'h2A, 0, 0);
        m2r[0]  = 1'b0;
        addr[0] = 8'h7F;
        @(negedge clk);
        check("bypass_mux", 0, 32'(mux_o[0]), 32'h7F);
        check("bypass_stall", 0, 32'(stall_o[0]), 32'h0);
        cycle();
        cycle();
        access(0, 0, 1, 0, 8'h10, 8'hC3, 2, 8'h10, 0, 0);
        access(0, 1, 0, 1, 8'h10, 8'h00, 2, 8'hC3, 0, 0);
        access(0, 1, 0, 1, 8'h11, 8'h00, 2, 8'h11, 0, 1);
        access(0, 1, 1, 1, 8'h05, 8'hEE, 2, 8'hEE, 1, 0);
        access(0, 1, 0, 1, 8'h05, 8'h00, 2, 8'hEE, 0, 0);
        access(0, 1, 0, 1, 8'hFF, 8'h00, 2, 8'hFF, 0, 0);

        access(1, 0, 1, 1, 8'h10, 8'hC3, 6, 8'h00, 0, 0);
        access(1, 1, 0, 1, 8'h10, 8'h00, 6, 8'hC3, 0, 0);
        access(1, 1, 0, 1, 8'h11, 8'h00, 6, 8'h11, 0, 1);
        access(1, 0, 1, 1, 8'h90, 8'h55, 6, 8'h00, 1, 0);
        access(1, 1, 0, 1, 8'h90, 8'h00, 6, 8'h00, 1, 0);
        access(1, 1, 0, 1, 8'h10, 8'h00, 6, 8'hC3, 0, 0);
        access(1, 1, 0, 1, 8'h7F, 8'h00, 6, 8'h7F, 0, 0);

        m2r[1]  = 1'b1;
        wr[1]   = 1'b1;
        addr[1] = 8'h20;
        wdat[1] = 8'hAA;
        cycle();
        cycle();
        rst[1] = 1'b1;
        wr[1]  = 1'b0;
        cycle();
        rst[1] = 1'b0;
        @(negedge clk);
        check("post_rst_stall", 1, 32'(stall_o[1]), 32'h0);
        check("post_rst_mux", 1, 32'(mux_o[1]), 32'h0);
        cycle();
        access(1, 1, 0, 1, 8'h20, 8'h00, 6, 8'h20, 0, 0);

        cycle();
        cycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
